adc_trigger_capture: RTL
========================

Name: adc_trigger_capture

Overview:
ADC-side consumer at the end of the DAC-to-ADC trigger register chain. Waits for a rising edge on the registered trigger bus, then captures a fixed-length frame of ADC samples. Emits the frame as an AXI4-Stream packet with tlast on the final sample. A small FIFO absorbs short downstream backpressure.

Parameters:
TRIG_WIDTH, 8, width of the trigger bus from the last trigger register stage
ADC_WIDTH, 14, ADC sample width; output tdata is zero-extended to 16 bits
FRAME_LEN, 256, samples per captured frame; legal range 2..65535
FIFO_DEPTH_LOG2, 4, output FIFO depth = 2^FIFO_DEPTH_LOG2 entries

Ports:
clk  in  1  sample clock, the same clock as the trigger register chain
rst_n  in  1  asynchronous active-low reset
arm  in  1  one-cycle pulse; arms capture when IDLE
trig_mask  in  TRIG_WIDTH  selects which trigger bits are valid trigger sources
trig_in  in  TRIG_WIDTH  q of the final trigger register stage
adc_data  in  ADC_WIDTH  ADC sample, valid every cycle
m_axis_tdata  out  16  captured sample, zero-extended
m_axis_tvalid  out  1  AXIS valid
m_axis_tready  in  1  AXIS ready
m_axis_tlast  out  1  high on sample FRAME_LEN-1 of the frame
busy  out  1  high in ARMED or CAPTURE
overflow  out  1  sticky; set when a sample is dropped, cleared by arm

Behaviour:
- Reset (async assert, release synchronous to clk):
  - state=IDLE, trig_d=0, sample counter=0, FIFO emptied.
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tdata=0, busy=0, overflow=0.
- Trigger detect: trig_d <= trig_in each cycle. hit = |((trig_in & ~trig_d) & trig_mask). A rising edge on any enabled bit is a hit; trig_mask=0 never triggers.
- FSM:
  - IDLE: arm -> ARMED, and overflow cleared in the same cycle.
  - ARMED: on hit -> CAPTURE. The adc_data present in the hit cycle is sample 0 and is written that cycle.
  - CAPTURE: write one sample per cycle, counter increments. When counter==FRAME_LEN-1, write the sample with its last flag set -> DRAIN.
  - DRAIN: when the FIFO is empty and the final beat has been accepted -> IDLE.
- arm outside IDLE is ignored. A hit outside ARMED is ignored.
- FIFO: write-side width ADC_WIDTH+1 (sample plus last flag); first-word-fall-through.
  - If the FIFO is full on a write cycle, that sample is dropped, overflow is set, and the counter still advances, so the frame length stays fixed.
  - If the dropped sample was the last one, the FIFO entry currently at the tail has its last flag forced to 1, so the packet is still terminated.
- Output: tvalid = FIFO not empty. Data is held stable while tvalid && !tready. A pop occurs on tvalid && tready. Latency from write to tvalid is 1 cycle.
- A simultaneous push and pop when full succeeds: the push is accepted and nothing is dropped.
- busy is combinational from the state.
- Reset mid-frame: the frame is aborted and tvalid drops immediately. Downstream must discard the partial packet.

Optional Feature:
ADC_CAPTURE_DELAY_EN
- Defined: adds a 16-bit input port trig_delay and a DELAY state between ARMED and CAPTURE.
  - On hit, load the down-counter with trig_delay.
  - Sample 0 is taken on the cycle the counter reaches 0.
  - trig_delay=0 behaves exactly as the undefined case.
  - trig_delay is sampled on the hit cycle only.
- Undefined: no port and no DELAY state; hit goes directly to CAPTURE.

Decomposition:
- Shared package adc_capture_pkg holds:
  - the state encoding constants IDLE/ARMED/DELAY/CAPTURE/DRAIN;
  - the AXIS data width constant (16);
  - the FRAME_LEN counter width function (clog2).
- One sub-module, capture_sync_fifo: a parameterised single-clock FWFT FIFO with full/empty flags and an async active-low reset.

Test Plan:
- Basic frame: FRAME_LEN=8, tready=1, trig_mask=0x01, arm, then trig_in 0x00->0x01 while adc_data ramps 100..107 -> 8 beats with tdata 100..107, tlast only on 107, busy low after the last beat.
- Mask and edge: trig_mask=0x02 while trig_in toggles bit 0 -> no capture. Hold trig_in=0x02 high before arm -> no capture until it falls and rises again.
- Backpressure: FIFO depth 16, FRAME_LEN=8, tready low for 5 cycles mid-frame -> all 8 samples delivered in order, overflow=0.
- Overflow: FRAME_LEN=64, tready=0 throughout -> exactly 16 beats are buffered; overflow=1. After tready=1, 16 beats drain and the 16th has tlast=1. A following arm clears overflow.
- Reset mid-operation: assert rst_n=0 at sample 3 of 8 -> tvalid=0 immediately, and state is IDLE after release. A subsequent arm plus trigger yields a clean 8-beat frame.
- With ADC_CAPTURE_DELAY_EN defined: trig_delay=5, hit at cycle T -> sample 0 equals the adc_data value at T+5. With trig_delay=0, sample 0 equals the adc_data value at T.

Source files
------------

// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC trigger capture block.
// FSM state encoding, AXIS width, frame counter width helper.
package adc_capture_pkg;

  localparam int AXIS_W = 16;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    DELAY   = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } state_t;

  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/adc_trigger_capture_if.sv
// AXI4-Stream beat bundle for captured ADC samples.
// master: tdata/tvalid/tlast out, tready in; slave: mirror.
interface adc_trigger_capture_if;
  import adc_capture_pkg::*;

  logic [AXIS_W-1:0] tdata;
  logic              tvalid;
  logic              tready;
  logic              tlast;

  modport master (
    output tdata, tvalid, tlast,
    input  tready
  );

  modport slave (
    input  tdata, tvalid, tlast,
    output tready
  );

endinterface

// File: rtl/capture_sync_fifo.sv
// Single-clock FWFT FIFO, 2^AW entries of W bits, MSB is a tag bit.
// Ports: push/wdata, pop/rdata, full/empty, mark_tail sets tail tag.
module capture_sync_fifo #(
  parameter int W  = 15,
  parameter int AW = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] wdata,
  input  logic         mark_tail,
  input  logic         pop,
  output logic [W-1:0] rdata,
  output logic         full,
  output logic         empty
);

  localparam int DEPTH = 1 << AW;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] tail;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  // a pop in the same cycle frees the slot, so a full push still lands
  assign do_push = push && (!full || do_pop);
  assign tail    = wr_ptr - AW'(1);
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem[wr_ptr] <= wdata;
    else if (mark_tail && !empty)
      mem[tail][W-1] <= 1'b1;
  end

endmodule

// File: rtl/adc_trigger_capture.sv
// Trigger-armed ADC frame capture emitting an AXIS packet via a FIFO.
// Ports: arm, trig_mask/trig_in, adc_data, m_axis, busy, overflow.
// ADC_CAPTURE_DELAY_EN adds trig_delay and a post-trigger DELAY state.
module adc_trigger_capture
  import adc_capture_pkg::*;
#(
  parameter int TRIG_WIDTH      = 8,
  parameter int ADC_WIDTH       = 14,
  parameter int FRAME_LEN       = 256,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  arm,
  input  logic [TRIG_WIDTH-1:0] trig_mask,
  input  logic [TRIG_WIDTH-1:0] trig_in,
  input  logic [ADC_WIDTH-1:0]  adc_data,
`ifdef ADC_CAPTURE_DELAY_EN
  input  logic [15:0]           trig_delay,
`endif
  adc_trigger_capture_if.master m_axis,
  output logic                  busy,
  output logic                  overflow
);

  localparam int CW = cnt_w(FRAME_LEN);
  localparam int FW = ADC_WIDTH + 1;

  state_t                state;
  logic [TRIG_WIDTH-1:0] trig_d;
  logic [CW-1:0]         cnt;
  logic                  hit;
  logic                  last;
  logic                  wr;
  logic                  wlast;
  logic                  pop;
  logic                  drop;
  logic                  full;
  logic                  empty;
  logic [FW-1:0]         rdata;
`ifdef ADC_CAPTURE_DELAY_EN
  logic [15:0]           dly;
`endif

  assign hit  = |((trig_in & ~trig_d) & trig_mask);
  assign last = cnt == CW'(FRAME_LEN - 1);
  assign busy = (state == ARMED) || (state == DELAY) ||
                (state == CAPTURE);

  always_comb begin
    wr = 1'b0;
    unique case (1'b1)
`ifdef ADC_CAPTURE_DELAY_EN
      state == ARMED:   wr = hit && (trig_delay == 16'd0);
      state == DELAY:   wr = dly == 16'd0;
`else
      state == ARMED:   wr = hit;
`endif
      state == CAPTURE: wr = 1'b1;
      default:          wr = 1'b0;
    endcase
  end

  // cnt is 0 for sample 0 and FRAME_LEN >= 2, so only CAPTURE can be last
  assign wlast = wr && last;
  assign pop   = m_axis.tvalid && m_axis.tready;
  assign drop  = wr && full && !pop;

  capture_sync_fifo #(
    .W  (FW),
    .AW (FIFO_DEPTH_LOG2)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr),
    .wdata     ({wlast, adc_data}),
    .mark_tail (drop && wlast),
    .pop       (pop),
    .rdata     (rdata),
    .full      (full),
    .empty     (empty)
  );

  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = AXIS_W'(rdata[ADC_WIDTH-1:0]);
  assign m_axis.tlast  = rdata[ADC_WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      trig_d   <= '0;
      cnt      <= '0;
      overflow <= 1'b0;
`ifdef ADC_CAPTURE_DELAY_EN
      dly      <= '0;
`endif
    end else begin
      trig_d <= trig_in;
      if (drop) overflow <= 1'b1;
      case (state)
        IDLE: if (arm) begin
          state    <= ARMED;
          overflow <= 1'b0;
        end
        ARMED: if (hit) begin
`ifdef ADC_CAPTURE_DELAY_EN
          if (trig_delay != 16'd0) begin
            // count down delay-1 so sample 0 lands exactly delay cycles on
            dly   <= trig_delay - 16'd1;
            state <= DELAY;
          end else begin
            cnt   <= CW'(1);
            state <= CAPTURE;
          end
`else
          cnt   <= CW'(1);
          state <= CAPTURE;
`endif
        end
`ifdef ADC_CAPTURE_DELAY_EN
        DELAY: if (dly == 16'd0) begin
          cnt   <= CW'(1);
          state <= CAPTURE;
        end else begin
          dly <= dly - 16'd1;
        end
`endif
        CAPTURE: if (last) begin
          cnt   <= '0;
          state <= DRAIN;
        end else begin
          cnt <= cnt + CW'(1);
        end
        DRAIN: if (empty) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
